// File: rtl/line_window_pkg.sv
// line_window_pkg
//   Shared defaults and elaboration-time helpers for the line window
//   generator. Imported by line_window_gen and lw_row_ram.
//   Contents:
//     DEFAULT_* localparams - default geometry of the block
//     lw_clog2()            - ceil(log2(value)), never below 1
//     lw_tap_lsb()          - LSB position of tap slice k in a packed column
package line_window_pkg;

  // ceil(log2(value)) with a floor of 1 so a counter is never zero bits wide
  function automatic int lw_clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w++;
    end
    return w;
  endfunction

  // Tap k occupies bits [k*width +: width] of the packed output column
  function automatic int lw_tap_lsb(input int tap, input int width);
    return tap * width;
  endfunction

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ROWS       = 3;
  localparam int DEFAULT_IMG_WIDTH  = 100;
  localparam int DEFAULT_ADDR_WIDTH = lw_clog2(DEFAULT_IMG_WIDTH);

endpackage : line_window_pkg

// File: rtl/lw_row_ram.sv
// lw_row_ram
//   One line memory of DEPTH pixels. A single address is shared by the
//   read and write sides: rd_data always shows the value currently stored
//   at addr (combinational read), and the write lands on the clock edge,
//   so a read and write to the same address in one cycle returns the old
//   contents. The array is intentionally not reset.
//   Ports:
//     clk     - rising-edge clock
//     addr    - column address
//     wr_en   - write strobe
//     wr_data - pixel to store
//     rd_data - pixel currently stored at addr
module lw_row_ram
  import line_window_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_IMG_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

endmodule : lw_row_ram

// File: rtl/line_window_gen.sv
// line_window_gen
//   Turns a raster pixel stream into a ROWS-tall vertical column per
//   accepted pixel. Slice k of data_out is the pixel k lines above the
//   current one in the same column (slice 0 is the current pixel). All
//   taps come out of one register stage, so they are already aligned.
//   Column and row-fill counters track frame position; sof restarts both.
//   Ports:
//     clk       - rising-edge clock
//     rst_n     - asynchronous active-low reset
//     sof       - start of frame, only meaningful with in_valid
//     data_in   - input pixel
//     in_valid  - input pixel qualifier (no backpressure)
//     data_out  - packed column, ROWS slices of DATA_WIDTH
//     out_valid - data_out qualifier, one cycle after the accepting edge
//     out_col   - column of data_out
//     out_eol   - out_valid on the last column of a line
//   Build option:
//     LINE_WINDOW_ZERO_FILL_EN - emit a column for every pixel from row 0
//     onward, with not-yet-filled taps forced to zero (top border padding).
//     Without it, out_valid stays low until ROWS-1 lines are buffered.
module line_window_gen
  import line_window_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ROWS       = DEFAULT_ROWS,
  parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sof,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       in_valid,
  output logic [ROWS*DATA_WIDTH-1:0] data_out,
  output logic                       out_valid,
  output logic [ADDR_WIDTH-1:0]      out_col,
  output logic                       out_eol
);

  localparam int FILL_WIDTH = lw_clog2(ROWS);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(IMG_WIDTH - 1);
  localparam logic [FILL_WIDTH-1:0] FILL_MAX = FILL_WIDTH'(ROWS - 1);

  logic [ADDR_WIDTH-1:0]      col_cnt_q, col_cnt_d;
  logic [FILL_WIDTH-1:0]      row_fill_q, row_fill_d;
  logic [ROWS*DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                       out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0]      out_col_q, out_col_d;
  logic                       out_eol_q, out_eol_d;

  // A pixel carrying sof is column 0 of a fresh, unfilled frame, so the
  // counters it sees are overridden before they address the memories.
  logic [ADDR_WIDTH-1:0] col_eff;
  logic [FILL_WIDTH-1:0] fill_eff;
  logic                  start_frame;

  assign start_frame = sof && in_valid;
  assign col_eff     = start_frame ? '0 : col_cnt_q;
  assign fill_eff    = start_frame ? '0 : row_fill_q;

  logic [DATA_WIDTH-1:0] rd_data [ROWS-1];
  logic [DATA_WIDTH-1:0] wr_data [ROWS-1];

  // Memory k holds the line k+1 above the current one. Each accepted pixel
  // pushes the column one memory further up: memory 0 takes the new pixel,
  // memory k takes what memory k-1 held before this edge.
  for (genvar g = 0; g < ROWS - 1; g++) begin : g_line
    if (g == 0) begin : g_first
      assign wr_data[g] = data_in;
    end else begin : g_chain
      assign wr_data[g] = rd_data[g-1];
    end

    lw_row_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_row_ram (
      .clk     (clk),
      .addr    (col_eff),
      .wr_en   (in_valid),
      .wr_data (wr_data[g]),
      .rd_data (rd_data[g])
    );
  end

  always_comb begin
    col_cnt_d   = col_cnt_q;
    row_fill_d  = row_fill_q;
    data_out_d  = data_out_q;
    out_col_d   = out_col_q;
    out_valid_d = 1'b0;
    out_eol_d   = 1'b0;

    if (in_valid) begin
      row_fill_d = fill_eff;
      if (col_eff == LAST_COL) begin
        col_cnt_d = '0;
        if (fill_eff != FILL_MAX) begin
          row_fill_d = fill_eff + FILL_WIDTH'(1);
        end
      end else begin
        col_cnt_d = col_eff + ADDR_WIDTH'(1);
      end

      data_out_d[lw_tap_lsb(0, DATA_WIDTH) +: DATA_WIDTH] = data_in;
      for (int k = 1; k < ROWS; k++) begin
`ifdef LINE_WINDOW_ZERO_FILL_EN
        // Lines above the top of the frame read as zero
        if (fill_eff < FILL_WIDTH'(k)) begin
          data_out_d[lw_tap_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = '0;
        end else begin
          data_out_d[lw_tap_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = rd_data[k-1];
        end
`else
        data_out_d[lw_tap_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = rd_data[k-1];
`endif
      end

      out_col_d = col_eff;
`ifdef LINE_WINDOW_ZERO_FILL_EN
      out_valid_d = 1'b1;
`else
      out_valid_d = (fill_eff == FILL_MAX);
`endif
      out_eol_d = out_valid_d && (col_eff == LAST_COL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_q   <= '0;
      row_fill_q  <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_eol_q   <= 1'b0;
    end else begin
      col_cnt_q   <= col_cnt_d;
      row_fill_q  <= row_fill_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
      out_eol_q   <= out_eol_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign out_col   = out_col_q;
  assign out_eol   = out_eol_q;

endmodule : line_window_gen

// File: tb/tb_line_window_gen.sv
// tb_line_window_gen
//   Self-checking bench for line_window_gen with ROWS=3, IMG_WIDTH=4.
//   The stimulus side remembers every pixel it sends by frame row and
//   column and queues the column the block should produce one cycle later;
//   a monitor pops one queue entry per driven cycle and compares.
//   Honours LINE_WINDOW_ZERO_FILL_EN when the design is built with it.
module tb_line_window_gen;

  localparam int DW   = 16;
  localparam int ROWS = 3;
  localparam int IW   = 4;
  localparam int AW   = 2;

  logic              clk;
  logic              rst_n;
  logic              sof;
  logic [DW-1:0]     data_in;
  logic              in_valid;
  logic [ROWS*DW-1:0] data_out;
  logic              out_valid;
  logic [AW-1:0]     out_col;
  logic              out_eol;

  line_window_gen #(
    .DATA_WIDTH (DW),
    .ROWS       (ROWS),
    .IMG_WIDTH  (IW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sof       (sof),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_col   (out_col),
    .out_eol   (out_eol)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic              valid;
    logic              eol;
    logic              chkData;
    logic              chkCol;
    logic [ROWS*DW-1:0] data;
    logic [AW-1:0]     col;
  } exp_t;

  exp_t expQueue[$];

  int checks   = 0;
  int failures = 0;

  // Frame-position model driven purely by what the stimulus sends
  logic [DW-1:0]      hist [0:15][0:IW-1];
  int                 frameRow = 0;
  int                 frameCol = 0;
  logic               lastKnown = 1'b0;
  logic [ROWS*DW-1:0] lastData  = '0;
  logic [AW-1:0]      lastCol   = '0;

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle of input at the falling edge and queue what the block
  // should show after the next rising edge
  task automatic applyStimulus(input logic s, input logic v, input logic [DW-1:0] px);
    exp_t e;
    logic zeroFill;
`ifdef LINE_WINDOW_ZERO_FILL_EN
    zeroFill = 1'b1;
`else
    zeroFill = 1'b0;
`endif
    @(negedge clk);
    sof      = s;
    in_valid = v;
    data_in  = px;
    e.data   = '0;
    e.col    = '0;
    if (v) begin
      if (s) begin
        frameRow = 0;
        frameCol = 0;
      end
      hist[frameRow][frameCol] = px;
      e.valid   = zeroFill || (frameRow >= ROWS - 1);
      e.eol     = e.valid && (frameCol == IW - 1);
      e.chkData = e.valid;
      e.chkCol  = e.valid;
      for (int k = 0; k < ROWS; k++) begin
        if (frameRow - k >= 0) begin
          e.data[k*DW +: DW] = hist[frameRow-k][frameCol];
        end
      end
      e.col     = AW'(frameCol);
      lastKnown = e.valid;
      lastData  = e.data;
      lastCol   = e.col;
      frameCol++;
      if (frameCol == IW) begin
        frameCol = 0;
        if (frameRow < 15) frameRow++;
      end
    end else begin
      e.valid   = 1'b0;
      e.eol     = 1'b0;
      e.chkData = lastKnown;
      e.chkCol  = lastKnown;
      e.data    = lastData;
      e.col     = lastCol;
    end
    expQueue.push_back(e);
  endtask

  // One image line, optionally with sof on its first pixel and idle gaps
  // after every pixel (the last gap lands at the line end)
  task automatic sendRow(input int r, input int base, input logic sof0, input int gap);
    for (int c = 0; c < IW; c++) begin
      applyStimulus(sof0 && (c == 0), 1'b1, DW'(base + r*16 + c));
      for (int g = 0; g < gap; g++) begin
        applyStimulus(g == 0, 1'b0, 16'hDEAD);
      end
    end
  endtask

  // Monitor: one queue entry per driven cycle, checked 1 unit after the edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (expQueue.size() > 0) begin
        e = expQueue.pop_front();
        checkOutput("out_valid", 64'(out_valid), 64'(e.valid));
        checkOutput("out_eol", 64'(out_eol), 64'(e.eol));
        if (e.chkData) checkOutput("data_out", 64'(data_out), 64'(e.data));
        if (e.chkCol)  checkOutput("out_col", 64'(out_col), 64'(e.col));
      end else if (out_valid) begin
        checkOutput("spurious_valid", 64'(out_valid), 64'd0);
      end
    end
  end

  task automatic checkResetState(input string phase);
    checkOutput({phase, "_data_out"}, 64'(data_out), 64'd0);
    checkOutput({phase, "_out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({phase, "_out_col"}, 64'(out_col), 64'd0);
    checkOutput({phase, "_out_eol"}, 64'(out_eol), 64'd0);
  endtask

  // Hard stop in case something wedges the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    sof      = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;

    // Frame A: four lines, no gaps
    for (int r = 0; r < 4; r++) sendRow(r, 0, r == 0, 0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);

    // Frame B: fill lines, then gapped lines (sof during a gap is ignored)
    sendRow(0, 0, 1'b1, 0);
    sendRow(1, 0, 1'b0, 0);
    sendRow(2, 0, 1'b0, 2);
    sendRow(3, 0, 1'b0, 1);

    // Frame C abandoned at row 1 col 2 by a new sof (frame D)
    sendRow(0, 'h40, 1'b1, 0);
    applyStimulus(1'b0, 1'b1, 16'h0050);
    applyStimulus(1'b0, 1'b1, 16'h0051);
    sendRow(0, 'h80, 1'b1, 0);
    sendRow(1, 'h80, 1'b0, 0);
    sendRow(2, 'h80, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 16'h00B0);
    applyStimulus(1'b0, 1'b1, 16'h00B1);

    // Asynchronous reset pulse in the middle of row 3
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkResetState("midreset");
    checkOutput("queue_at_reset", 64'(expQueue.size()), 64'd0);
    expQueue.delete();
    frameRow  = 0;
    frameCol  = 0;
    lastKnown = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // After reset: no sof, first pixel is row 0
    for (int r = 0; r < 3; r++) sendRow(r, 'hC0, 1'b0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0);

    @(posedge clk);
    #3;
    checkOutput("queue_drained", 64'(expQueue.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_line_window_gen
